// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the 5-stage CPU: the NOP encoding, instruction field
// positions, the opcodes the hazard logic cares about, and a field helper.
// ---------------------------------------------------------------------------
package cpu_pkg;

    // All-zero word decodes as a no-operation in every stage.
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Instruction field positions.
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RD_MSB  = 26;
    localparam int RD_LSB  = 22;
    localparam int RS_MSB  = 21;
    localparam int RS_LSB  = 17;
    localparam int RT_MSB  = 16;
    localparam int RT_LSB  = 12;

    typedef enum logic [4:0] {
        OP_BLT = 5'b00110,
        OP_SW  = 5'b00111,
        OP_LW  = 5'b01000
    } opcode_e;

    // Extracts the opcode field of an instruction word.
    function automatic logic [4:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that increments by one on each clock edge with inc=1 and
// sticks at all-ones instead of wrapping.
// Ports:
//   clock  in          rising-edge clock
//   clr_n  in          asynchronous active-low clear
//   inc    in          count this edge
//   count  out [W-1:0] registered count value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] count_r;

    // Saturating count register with asynchronous clear.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            count_r <= CNT_ZERO;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/fetch_fd_stage.sv
// ---------------------------------------------------------------------------
// fetch_fd_stage
// Fetch stage and F/D pipeline latch. Owns the PC, addresses instruction
// memory with the low PC bits, and advances, holds or flushes the F/D latch
// under the multdiv stall, redirect and load-use stall controls (in that
// priority). Tells D/X when to bubble or flush, and counts stall and flush
// events with saturating counters.
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   stall_ld, stall_md      load-use stall, multdiv freeze of F/D/X
//   redirect, redirect_pc   taken branch/jump from X and its target
//   imem_addr, imem_q       instruction memory address / same-cycle data
//   pc_f                    current fetch PC
//   pc_fd, ir_fd, valid_fd  F/D latch: PC+1, instruction, valid flag
//   bubble_dx, flush_dx     D/X must load a NOP (stall / redirect)
//   stall_cnt, flush_cnt    saturating event counters
// ---------------------------------------------------------------------------
module fetch_fd_stage
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH        = 32,
    parameter int IMEM_ADDR_WIDTH = 12,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       stall_ld,
    input  logic                       stall_md,
    input  logic                       redirect,
    input  logic [PC_WIDTH-1:0]        redirect_pc,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]                imem_q,
    output logic [PC_WIDTH-1:0]        pc_f,
    output logic [PC_WIDTH-1:0]        pc_fd,
    output logic [31:0]                ir_fd,
    output logic                       valid_fd,
    output logic                       bubble_dx,
    output logic                       flush_dx,
    output logic [CNT_WIDTH-1:0]       stall_cnt,
    output logic [CNT_WIDTH-1:0]       flush_cnt
);

    localparam logic [PC_WIDTH-1:0] PC_ZERO = {PC_WIDTH{1'b0}};
    localparam logic [PC_WIDTH-1:0] PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic [PC_WIDTH-1:0] pc_f_r;
    logic [PC_WIDTH-1:0] pc_fd_r;
    logic [31:0]         ir_fd_r;
    logic                valid_fd_r;
    logic [PC_WIDTH-1:0] pc_inc_s;
    logic                flush_dx_s;
    logic                bubble_dx_s;
    logic                stall_inc_s;

    // Next sequential PC (wraps modulo 2^PC_WIDTH) and the D/X controls.
    always_comb begin
        pc_inc_s    = pc_f_r + PC_ONE;
        flush_dx_s  = redirect & ~stall_md;
        bubble_dx_s = stall_ld & ~redirect & ~stall_md;
        // The PC is held when multdiv freezes or a load-use stall wins.
        stall_inc_s = stall_md | bubble_dx_s;
    end

    // PC and F/D latch: multdiv freeze > redirect > load-use stall > advance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_f_r     <= PC_ZERO;
            pc_fd_r    <= PC_ZERO;
            ir_fd_r    <= NOP;
            valid_fd_r <= 1'b0;
        end else if (stall_md) begin
            // X is frozen too, so a pending redirect re-asserts later.
            pc_f_r     <= pc_f_r;
            pc_fd_r    <= pc_fd_r;
            ir_fd_r    <= ir_fd_r;
            valid_fd_r <= valid_fd_r;
        end else if (redirect) begin
            pc_f_r     <= redirect_pc;
            pc_fd_r    <= PC_ZERO;
            ir_fd_r    <= NOP;
            valid_fd_r <= 1'b0;
        end else if (stall_ld) begin
            pc_f_r     <= pc_f_r;
            pc_fd_r    <= pc_fd_r;
            ir_fd_r    <= ir_fd_r;
            valid_fd_r <= valid_fd_r;
        end else begin
            pc_f_r     <= pc_inc_s;
            pc_fd_r    <= pc_inc_s;
            ir_fd_r    <= imem_q;
            valid_fd_r <= 1'b1;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clock (clock),
        .clr_n (reset_n),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clock (clock),
        .clr_n (reset_n),
        .inc   (flush_dx_s),
        .count (flush_cnt)
    );

    assign imem_addr = pc_f_r[IMEM_ADDR_WIDTH-1:0];
    assign pc_f      = pc_f_r;
    assign pc_fd     = pc_fd_r;
    assign ir_fd     = ir_fd_r;
    assign valid_fd  = valid_fd_r;
    assign flush_dx  = flush_dx_s;
    assign bubble_dx = bubble_dx_s;

endmodule
